uart_rxsm_gen: RTL and testbench
================================

Name: uart_rxsm_gen

Overview:
Parametrised asynchronous serial receive state machine for the SSP UART family. It supports 5 to pMaxLen data bits, odd/even/space/mark parity, 1 or 2 stop bits, and a configurable oversampling ratio. Each bit is taken as a 3-sample majority vote at mid-bit. Parity error, framing error and line break are reported as separate flags. The block writes one word per frame into the receive holding register/FIFO through a single-cycle write strobe.

Parameters:
pMaxLen, 8, maximum data bits. Legal range 5..9; sets the RD width.
pOvs, 16, CE_Ovs ticks per bit. Even, >= 8.
pCntW, 4, phase counter width. Must satisfy 2^pCntW >= pOvs.

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous active-high reset
CE_Ovs  in  1  oversample clock enable, one Clk wide, baud x pOvs
Len  in  3  data bits minus 5 (0=5 .. 4=9); values above pMaxLen-5 are clamped to pMaxLen
NumStop  in  1  0: 1 stop bit; 1: 2 stop bits
ParEn  in  1  parity bit present
Par  in  2  0 odd, 1 even, 2 space, 3 mark
RxD  in  1  asynchronous serial input
RD  out  pMaxLen  received data, LSB-aligned, unused upper bits 0
PE  out  1  parity error for the word in RD
FE  out  1  framing error (stop bit sampled 0)
BRK  out  1  break detected
WE_RHR  out  1  one-Clk write strobe for RD/PE/FE/BRK
RxIdle  out  1  in Idle, waiting for start bit
RxBusy  out  1  in ChkStart, Shift, Parity or Stop states
RxError  out  1  in Error state

Behaviour:
- Reset: Clk is the clock; Rst is synchronous and active-high. On Rst, RD=0, PE=FE=BRK=0, WE_RHR=0, state=WaitMark, phase=0, bit count=0. RxD synchronizer flops preset to 1.
- Input path: RxD passes through 2 flops. On every CE_Ovs the synchronized value shifts into a 3-bit sample history.
- Bit value (Vote) is the majority of the 3-bit history, evaluated at each decision point.
- Phase counter: counts CE_Ovs ticks. Held at 0 in WaitMark and Idle.
  - ChkStart decision occurs on the pOvs/2-th tick after entry.
  - Every later decision occurs every pOvs ticks. The counter reloads at each decision.
- Configuration inputs are sampled on the Idle->ChkStart transition and held constant for the rest of the frame.
- WaitMark: on CE_Ovs, go to Idle once synchronized RxD has been 1 for 2 consecutive ticks.
- Idle: on CE_Ovs with synchronized RxD=0, go to ChkStart. Clear the shift register and parity accumulator.
- ChkStart (at decision): Vote=1 -> back to Idle as a glitch, no write. Vote=0 -> Shift with bit count=0.
- Shift (at decision):
  - Vote goes into the shift register LSB-first and is XORed into the parity accumulator.
  - Bit count increments.
  - After Len+5 bits: go to Parity if ParEn, else Stop.
- Parity (at decision):
  - Odd mode: PE_n = ~(acc ^ Vote).
  - Even mode: PE_n = acc ^ Vote.
  - Space mode: PE_n = Vote.
  - Mark mode: PE_n = ~Vote.
  - Go to Stop.
- Stop (at decision), with NumStop=1, first stop bit:
  - Vote=1 -> second stop bit.
  - Vote=0 -> FE path.
- Stop (at decision), final stop bit:
  - Vote=1 -> commit with FE=0, go to Idle.
  - Vote=0 -> FE path.
- FE path:
  - All data bits 0, parity bit (if present) 0, and stop bit 0 -> commit with BRK=1, FE=1, PE=0, RD=0.
  - Otherwise commit with FE=1.
  - In both cases go to Error.
- Error: lasts one CE_Ovs tick, then goes to WaitMark. Another frame cannot start until the line returns to mark.
- Commit: registered. RD/PE/FE/BRK update and WE_RHR=1 on the Clk after the deciding CE_Ovs. WE_RHR lasts exactly one Clk. Outputs hold until the next commit.
- Latency: the write occurs one Clk after the mid-point decision of the final stop bit. For 2-stop-bit frames, that point is mid of stop bit 2.
- Mid-frame Rst aborts the frame with no write, and the block returns to WaitMark.
- Illegal state encodings recover to WaitMark on the next Clk.
- Status outputs are decoded combinationally from the state register.

Test Plan:
- pOvs=16, 8N1, 0xA5 framed at exact baud -> one WE_RHR pulse; RD=0x0A5 (9-bit build RD=9'h0A5); PE=FE=BRK=0; RxIdle=1 afterwards.
- 7E1, 0x41 with parity bit sent as 1 -> RD=0x41, PE=1, FE=0; 2nd frame 0x41 with parity 0 -> PE=0.
- 8N2, 0x3C with second stop bit 0 -> RD=0x3C, FE=1, RxError pulses; next frame ignored until line high for 2 ticks, then 0x55 received correctly.
- Line held low for 12 bit times -> single write with BRK=1, FE=1, RD=0; no second write until line returns high.
- Start bit low for only 3 ticks -> returns to Idle, no WE_RHR. 1-tick low glitch at mid of data bit 3 of 0xFF -> RD=0xFF (majority rejects).
- Rst asserted during bit 4 of 0x96 -> no write; state WaitMark; following 0x96 frame received correctly.

Source files
------------

// File: rtl/uart_rxsm_gen_if.sv
// Bundle of the UART receive state machine's configuration, serial input and
// receive-holding-register write signals.
interface uart_rxsm_gen_if #(
    parameter int pMaxLen = 8
);
    logic               CE_Ovs;
    logic [2:0]         Len;
    logic               NumStop;
    logic               ParEn;
    logic [1:0]         Par;
    logic               RxD;
    logic [pMaxLen-1:0] RD;
    logic               PE;
    logic               FE;
    logic               BRK;
    logic               WE_RHR;
    logic               RxIdle;
    logic               RxBusy;
    logic               RxError;

    modport master (
        output CE_Ovs, Len, NumStop, ParEn, Par, RxD,
        input  RD, PE, FE, BRK, WE_RHR, RxIdle, RxBusy, RxError
    );

    modport slave (
        input  CE_Ovs, Len, NumStop, ParEn, Par, RxD,
        output RD, PE, FE, BRK, WE_RHR, RxIdle, RxBusy, RxError
    );
endinterface

// File: rtl/uart_rxsm_gen.sv
// Asynchronous serial receive state machine: 3-sample majority vote at mid-bit,
// 5..pMaxLen data bits, optional parity, 1/2 stop bits, break and framing detection.
module uart_rxsm_gen #(
    parameter int pMaxLen = 8,
    parameter int pOvs    = 16,
    parameter int pCntW   = 4
) (
    input  logic           Clk,
    input  logic           Rst,
    uart_rxsm_gen_if.slave bus
);

    typedef enum logic [2:0] {
        sWaitMark = 3'd0,
        sIdle     = 3'd1,
        sChkStart = 3'd2,
        sShift    = 3'd3,
        sParity   = 3'd4,
        sStop     = 3'd5,
        sError    = 3'd6
    } state_t;

    localparam logic [pCntW-1:0] cHalf = pCntW'(pOvs / 2 - 1);
    localparam logic [pCntW-1:0] cFull = pCntW'(pOvs - 1);

    function automatic logic majority3(input logic [2:0] h);
        return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
    endfunction

    function automatic logic parityErr(input logic [1:0] mode, input logic acc, input logic v);
        case (mode)
            2'd0:    return ~(acc ^ v);
            2'd1:    return acc ^ v;
            2'd2:    return v;
            default: return ~v;
        endcase
    endfunction

    // Len encodes bits-5; anything beyond the build's width is clamped to pMaxLen.
    function automatic logic [3:0] clampLen(input logic [2:0] len);
        logic [3:0] n;
        n = {1'b0, len} + 4'd5;
        if (n > 4'(pMaxLen)) n = 4'(pMaxLen);
        return n;
    endfunction

    state_t             state, stateNxt;
    logic               rxdMeta_p0, rxdSync_p1;
    logic [2:0]         hist;
    logic [pCntW-1:0]   phase;
    logic [3:0]         bitCnt;
    logic               vote, atDecision, frameStart;
    logic               doCommit, commitFe, commitBrk;
    logic [pMaxLen-1:0] shReg, rdQ;
    logic               parAcc, allZero, peCalc, stop1Done;
    logic [3:0]         nBitsQ;
    logic               numStopQ, parEnQ;
    logic [1:0]         parQ;
    logic               peQ, feQ, brkQ, weQ;

    assign vote       = majority3(hist);
    assign frameStart = (state == sIdle) && bus.CE_Ovs && !rxdSync_p1;

    always_comb begin
        atDecision = 1'b0;
        if (bus.CE_Ovs) begin
            if (state == sChkStart)
                atDecision = (phase == cHalf);
            else if (state == sShift || state == sParity || state == sStop)
                atDecision = (phase == cFull);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) state <= sWaitMark;
        else     state <= stateNxt;
    end

    always_comb begin
        stateNxt  = state;
        doCommit  = 1'b0;
        commitFe  = 1'b0;
        commitBrk = 1'b0;
        case (state)
            sWaitMark: if (bus.CE_Ovs && rxdSync_p1 && hist[0]) stateNxt = sIdle;
            sIdle:     if (frameStart) stateNxt = sChkStart;
            sChkStart: if (atDecision) stateNxt = vote ? sIdle : sShift;
            sShift:    if (atDecision && (bitCnt + 4'd1) == nBitsQ)
                           stateNxt = parEnQ ? sParity : sStop;
            sParity:   if (atDecision) stateNxt = sStop;
            sStop: begin
                if (atDecision) begin
                    if (vote) begin
                        if (!(numStopQ && !stop1Done)) begin
                            doCommit = 1'b1;
                            stateNxt = sIdle;
                        end
                    end else begin
                        doCommit  = 1'b1;
                        commitFe  = 1'b1;
                        commitBrk = allZero;
                        stateNxt  = sError;
                    end
                end
            end
            sError:    if (bus.CE_Ovs) stateNxt = sWaitMark;
            default:   stateNxt = sWaitMark;
        endcase
    end

    // Stage p0/p1: two-flop synchronizer, then oversample history and phase
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rxdMeta_p0 <= 1'b1;
            rxdSync_p1 <= 1'b1;
            hist       <= 3'b000;
            phase      <= '0;
            bitCnt     <= '0;
        end else begin
            rxdMeta_p0 <= bus.RxD;
            rxdSync_p1 <= rxdMeta_p0;
            if (bus.CE_Ovs) hist <= {hist[1:0], rxdSync_p1};
            if (state == sWaitMark || state == sIdle)
                phase <= '0;
            else if (bus.CE_Ovs)
                phase <= atDecision ? '0 : phase + pCntW'(1);
            if (atDecision && state == sChkStart)
                bitCnt <= '0;
            else if (atDecision && state == sShift)
                bitCnt <= bitCnt + 4'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (frameStart) begin
            shReg     <= '0;
            parAcc    <= 1'b0;
            allZero   <= 1'b1;
            stop1Done <= 1'b0;
            nBitsQ    <= clampLen(bus.Len);
            numStopQ  <= bus.NumStop;
            parEnQ    <= bus.ParEn;
            parQ      <= bus.Par;
        end else if (atDecision) begin
            case (state)
                sShift: begin
                    for (int i = 0; i < pMaxLen; i++)
                        if (bitCnt == 4'(i)) shReg[i] <= vote;
                    parAcc  <= parAcc ^ vote;
                    allZero <= allZero & ~vote;
                end
                sParity: begin
                    peCalc  <= parityErr(parQ, parAcc, vote);
                    allZero <= allZero & ~vote;
                end
                sStop:   stop1Done <= 1'b1;
                default: ;
            endcase
        end
    end

    // Stage p2: registered commit into the receive holding register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rdQ  <= '0;
            peQ  <= 1'b0;
            feQ  <= 1'b0;
            brkQ <= 1'b0;
            weQ  <= 1'b0;
        end else begin
            weQ <= doCommit;
            if (doCommit) begin
                rdQ  <= commitBrk ? '0 : shReg;
                peQ  <= !commitBrk && parEnQ && peCalc;
                feQ  <= commitFe;
                brkQ <= commitBrk;
            end
        end
    end

    assign bus.RD      = rdQ;
    assign bus.PE      = peQ;
    assign bus.FE      = feQ;
    assign bus.BRK     = brkQ;
    assign bus.WE_RHR  = weQ;
    assign bus.RxIdle  = (state == sIdle);
    assign bus.RxBusy  = (state == sChkStart) || (state == sShift) ||
                         (state == sParity) || (state == sStop);
    assign bus.RxError = (state == sError);

endmodule

// File: tb/tb_uart_rxsm_gen.sv
// Directed bench for uart_rxsm_gen: pOvs=16, CE_Ovs every 4 Clk, frames built tick by tick.
module tb_uart_rxsm_gen;

    logic Clk;
    logic Rst;
    int   checks = 0;
    int   errors = 0;
    int   weCount = 0;
    int   weRun = 0;
    int   maxWe = 0;
    bit   errSeen = 0;
    logic [1:0] ceDiv = 2'd0;
    int   wb;

    uart_rxsm_gen_if #(.pMaxLen(8)) bus ();

    uart_rxsm_gen #(.pMaxLen(8), .pOvs(16), .pCntW(4)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        ceDiv = ceDiv + 2'd1;
        bus.CE_Ovs = (ceDiv == 2'd0);
    end

    always @(negedge Clk) begin
        if (bus.WE_RHR === 1'b1) begin
            weCount = weCount + 1;
            weRun = weRun + 1;
            if (weRun > maxWe) maxWe = weRun;
        end else begin
            weRun = 0;
        end
        if (bus.RxError === 1'b1) errSeen = 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic waitTick();
        @(posedge Clk);
        while (bus.CE_Ovs !== 1'b1) @(posedge Clk);
    endtask

    // Drive a level, hold it for n oversample ticks, return just after the last tick.
    task automatic sendLevel(input logic v, input int n);
        bus.RxD = v;
        repeat (n) waitTick();
        @(negedge Clk);
    endtask

    task automatic sendFrame(input logic [8:0] d, input int nb, input bit hasPar, input logic pb,
                             input int nStop, input logic lastStop, input int glitchBit,
                             input int rstBit);
        sendLevel(1'b0, 16);
        for (int i = 0; i < nb; i++) begin
            if (i == glitchBit) begin
                sendLevel(d[i], 6);
                sendLevel(~d[i], 1);
                sendLevel(d[i], 9);
            end else if (i == rstBit) begin
                sendLevel(d[i], 8);
                Rst = 1'b1;
                sendLevel(d[i], 8);
            end else begin
                sendLevel(d[i], 16);
            end
        end
        if (hasPar) sendLevel(pb, 16);
        for (int s = 0; s < nStop; s++)
            sendLevel((s == nStop - 1) ? lastStop : 1'b1, 16);
    endtask

    initial begin
        Rst = 1'b1;
        bus.RxD = 1'b1;
        bus.Len = 3'd3;
        bus.NumStop = 1'b0;
        bus.ParEn = 1'b0;
        bus.Par = 2'd0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_rd", 32'(bus.RD), 32'h0);
        check("rst_pe", 32'(bus.PE), 32'h0);
        check("rst_fe", 32'(bus.FE), 32'h0);
        check("rst_brk", 32'(bus.BRK), 32'h0);
        check("rst_we", 32'(bus.WE_RHR), 32'h0);
        check("rst_idle", 32'(bus.RxIdle), 32'h0);
        check("rst_busy", 32'(bus.RxBusy), 32'h0);
        check("rst_err", 32'(bus.RxError), 32'h0);
        Rst = 1'b0;
        sendLevel(1'b1, 8);
        check("mark_idle", 32'(bus.RxIdle), 32'h1);

        // 8N1 0xA5
        wb = weCount;
        sendFrame(9'h0A5, 8, 0, 1'b0, 1, 1'b1, -1, -1);
        sendLevel(1'b1, 4);
        check("a5_we", 32'(weCount - wb), 32'd1);
        check("a5_rd", 32'(bus.RD), 32'h0A5);
        check("a5_pe", 32'(bus.PE), 32'h0);
        check("a5_fe", 32'(bus.FE), 32'h0);
        check("a5_brk", 32'(bus.BRK), 32'h0);
        check("a5_idle", 32'(bus.RxIdle), 32'h1);

        // Len=4 clamps to 8 bits in this build
        bus.Len = 3'd4;
        sendFrame(9'h05A, 8, 0, 1'b0, 1, 1'b1, -1, -1);
        sendLevel(1'b1, 4);
        check("clamp_rd", 32'(bus.RD), 32'h05A);
        check("clamp_fe", 32'(bus.FE), 32'h0);

        // 5N1
        bus.Len = 3'd0;
        sendFrame(9'h015, 5, 0, 1'b0, 1, 1'b1, -1, -1);
        sendLevel(1'b1, 4);
        check("len5_rd", 32'(bus.RD), 32'h015);

        // 7E1 0x41: correct parity bit is 0
        bus.Len = 3'd2;
        bus.ParEn = 1'b1;
        bus.Par = 2'd1;
        sendFrame(9'h041, 7, 1, 1'b1, 1, 1'b1, -1, -1);
        sendLevel(1'b1, 4);
        check("e_bad_rd", 32'(bus.RD), 32'h041);
        check("e_bad_pe", 32'(bus.PE), 32'h1);
        check("e_bad_fe", 32'(bus.FE), 32'h0);
        sendFrame(9'h041, 7, 1, 1'b0, 1, 1'b1, -1, -1);
        sendLevel(1'b1, 4);
        check("e_ok_pe", 32'(bus.PE), 32'h0);

        // 7O1 with parity 0 is wrong; mark with parity 1 is right
        bus.Par = 2'd0;
        sendFrame(9'h041, 7, 1, 1'b0, 1, 1'b1, -1, -1);
        sendLevel(1'b1, 4);
        check("odd_pe", 32'(bus.PE), 32'h1);
        bus.Par = 2'd3;
        sendFrame(9'h041, 7, 1, 1'b1, 1, 1'b1, -1, -1);
        sendLevel(1'b1, 4);
        check("mark_pe", 32'(bus.PE), 32'h0);

        // 8N2 0x3C with bad second stop bit
        bus.Len = 3'd3;
        bus.ParEn = 1'b0;
        bus.NumStop = 1'b1;
        errSeen = 0;
        wb = weCount;
        sendFrame(9'h03C, 8, 0, 1'b0, 2, 1'b0, -1, -1);
        check("fe_we", 32'(weCount - wb), 32'd1);
        check("fe_rd", 32'(bus.RD), 32'h03C);
        check("fe_fe", 32'(bus.FE), 32'h1);
        check("fe_brk", 32'(bus.BRK), 32'h0);
        check("fe_errstate", 32'(errSeen), 32'h1);
        sendLevel(1'b1, 1);
        sendLevel(1'b0, 16);
        check("fe_wait_idle", 32'(bus.RxIdle), 32'h0);
        check("fe_wait_busy", 32'(bus.RxBusy), 32'h0);
        check("fe_wait_we", 32'(weCount - wb), 32'd1);
        sendLevel(1'b1, 32);
        sendFrame(9'h055, 8, 0, 1'b0, 2, 1'b1, -1, -1);
        sendLevel(1'b1, 4);
        check("n2_rd", 32'(bus.RD), 32'h055);
        check("n2_fe", 32'(bus.FE), 32'h0);

        // Line break: low for 12 bit times
        bus.NumStop = 1'b0;
        wb = weCount;
        sendLevel(1'b0, 192);
        check("brk_we", 32'(weCount - wb), 32'd1);
        check("brk_brk", 32'(bus.BRK), 32'h1);
        check("brk_fe", 32'(bus.FE), 32'h1);
        check("brk_rd", 32'(bus.RD), 32'h0);
        check("brk_pe", 32'(bus.PE), 32'h0);
        check("brk_idle", 32'(bus.RxIdle), 32'h0);
        check("brk_busy", 32'(bus.RxBusy), 32'h0);
        sendLevel(1'b1, 32);
        check("brk_we_after", 32'(weCount - wb), 32'd1);
        check("brk_idle_after", 32'(bus.RxIdle), 32'h1);

        // Short start pulse is a glitch
        wb = weCount;
        sendLevel(1'b0, 3);
        sendLevel(1'b1, 32);
        check("glitch_start_we", 32'(weCount - wb), 32'd0);
        check("glitch_start_idle", 32'(bus.RxIdle), 32'h1);

        // One-tick dip at mid of data bit 3 of 0xFF
        sendFrame(9'h0FF, 8, 0, 1'b0, 1, 1'b1, 3, -1);
        sendLevel(1'b1, 4);
        check("vote_we", 32'(weCount - wb), 32'd1);
        check("vote_rd", 32'(bus.RD), 32'h0FF);

        // Reset during data bit 4 of 0x96, held to end of frame
        wb = weCount;
        sendFrame(9'h096, 8, 0, 1'b0, 1, 1'b1, -1, 4);
        check("rst_mid_we", 32'(weCount - wb), 32'd0);
        check("rst_mid_rd", 32'(bus.RD), 32'h0);
        check("rst_mid_busy", 32'(bus.RxBusy), 32'h0);
        check("rst_mid_idle", 32'(bus.RxIdle), 32'h0);
        Rst = 1'b0;
        sendLevel(1'b1, 32);
        sendFrame(9'h096, 8, 0, 1'b0, 1, 1'b1, -1, -1);
        sendLevel(1'b1, 4);
        check("rst_after_we", 32'(weCount - wb), 32'd1);
        check("rst_after_rd", 32'(bus.RD), 32'h096);

        check("we_width", 32'(maxWe), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
